sincos_arbiter: RTL and testbench

- Shares one sincos evaluation unit (start/done handshake, 32-bit single-precision operand, sine and cosine results) between NUM_REQ requesters.
- Arbitration is round-robin. The block sequences each operation through the unit, enforces a minimum settle window, and detects timeouts.
- Results go back on a single response channel tagged with the requester ID.
- Sits between the FP operation dispatch logic and the sincos unit.

---
 rtl/sincos_arbiter.sv | 149 ++++++++++++++
 tb/tb_sincos_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_arbiter.sv
// Round-robin arbiter that shares one sincos unit between NUM_REQ requesters.
// Each operation runs IDLE -> ISSUE -> WAIT -> RESP and returns a tagged response.
module sincos_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_opx,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_sine,
  output logic [31:0]             rsp_cosine,
  output logic                    rsp_timeout,
  output logic                    unit_start,
  output logic [31:0]             unit_opx,
  input  logic [31:0]             unit_sine,
  input  logic [31:0]             unit_cosine,
  input  logic                    unit_done,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]     opx_q, opx_d;
  logic [31:0]     sine_q, sine_d;
  logic [31:0]     cosine_q, cosine_d;
  logic            timeout_q, timeout_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  // Circular scan from rr_ptr; iterating downwards lets the nearest requester win.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      idx = (int'(rr_ptr_q) + j) % NUM_REQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      wait_cnt_q <= '0;
      opx_q      <= '0;
      sine_q     <= '0;
      cosine_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      wait_cnt_q <= wait_cnt_d;
      opx_q      <= opx_d;
      sine_q     <= sine_d;
      cosine_q   <= cosine_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    wait_cnt_d = wait_cnt_q;
    opx_d      = opx_q;
    sine_d     = sine_q;
    cosine_d   = cosine_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          opx_d    = req_opx[32*grant_idx +: 32];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Early done (including one held over from a previous op) is ignored.
        if (unit_done && (wait_cnt_q >= 8'(MIN_WAIT))) begin
          sine_d    = unit_sine;
          cosine_d  = unit_cosine;
          timeout_d = 1'b0;
          state_d   = ST_RESP;
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          sine_d    = '0;
          cosine_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshakes: a transfer happens on the edge where valid and ready are both high;
  // the producer holds valid and payload stable until then.
  always_comb begin
    req_ready  = '0;
    unit_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  if (grant_found && n_rst) req_ready = NUM_REQ'(1) << grant_idx;
      ST_ISSUE: unit_start = 1'b1;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign unit_opx    = opx_q;
  assign rsp_id      = id_q;
  assign rsp_sine    = sine_q;
  assign rsp_cosine  = cosine_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_sincos_arbiter.sv
// Bench for sincos_arbiter: behavioural sincos unit, round-robin reference and
// a response scoreboard keyed on grants.
module tb_sincos_arbiter;
  localparam int NR  = 4;
  localparam int MW  = 1;
  localparam int TO  = 64;
  localparam int IDW = 2;
  localparam int W   = 1 + IDW + 64;
  localparam logic [31:0] CMASK = 32'hA5A5A5A5;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic [NR-1:0]   req_valid, req_ready;
  logic [32*NR-1:0] req_opx;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_sine, rsp_cosine, unit_opx, unit_sine, unit_cosine;
  logic            rsp_timeout, unit_start, unit_done, busy;

  sincos_arbiter #(.NUM_REQ(NR), .MIN_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_opx(req_opx),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sine(rsp_sine), .rsp_cosine(rsp_cosine),
    .rsp_timeout(rsp_timeout), .unit_start(unit_start), .unit_opx(unit_opx),
    .unit_sine(unit_sine), .unit_cosine(unit_cosine), .unit_done(unit_done),
    .busy(busy)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- check task and counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int j = 0; j < NR; j++)
      if (v[(p + j) % NR]) return (p + j) % NR;
    return 0;
  endfunction

  // ---------------- behavioural sincos unit (0 pulse, 1 done held high, 2 done held low)
  int          unit_mode = 0;
  int          lat = 2;
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_op;

  initial begin
    unit_done = 1'b0; unit_sine = '0; unit_cosine = '0; m_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        m_pend = 1'b0; unit_done = 1'b0;
      end else if (unit_mode == 1) begin
        unit_done = 1'b1; unit_sine = ~unit_opx; unit_cosine = unit_opx ^ CMASK;
      end else if (unit_mode == 2) begin
        unit_done = 1'b0; unit_sine = $urandom; unit_cosine = $urandom;
      end else if (unit_start) begin
        m_pend = 1'b1; m_cnt = lat; m_op = unit_opx; unit_done = 1'b0;
      end else if (m_pend && m_cnt == 0) begin
        unit_done = 1'b1; unit_sine = ~m_op; unit_cosine = m_op ^ CMASK; m_pend = 1'b0;
      end else begin
        if (m_pend) m_cnt--;
        unit_done = 1'b0; unit_sine = $urandom; unit_cosine = $urandom;
      end
    end
  end

  // ---------------- scoreboard / monitor
  logic [W-1:0]   exp_q[$];
  int             wait_q[$];
  int             grant_log[$];
  int             n_grants = 0, n_rsp = 0, tb_rr = 0;
  int             wait_cycles = 0, n_starts = 0, eg = 0, gi = 0;
  logic [IDW-1:0] eg_w;
  logic [31:0]    cur_opx = '0;
  int             last_g = -1;
  bit             prev_rv = 1'b0, stall_prev = 1'b0;
  logic [W-1:0]   held_rsp, got_rsp;

  assign got_rsp = {rsp_timeout, rsp_id, rsp_sine, rsp_cosine};

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_rv = 1'b0; stall_prev = 1'b0;
    end else begin
      if (busy) check("rdy_busy", req_ready, 0);
      else if (req_valid != 0) begin
        eg = rr_pick(req_valid, tb_rr);
        check("rdy_onehot", $onehot(req_ready), 1);
        gi = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
        check("grant_id", gi, eg);
        tb_rr = (eg + 1) % NR; last_g = eg; n_grants++; n_starts = 0;
        grant_log.push_back(eg);
        cur_opx = req_opx[32*eg +: 32];
        eg_w = IDW'(eg);
        if (unit_mode == 2) exp_q.push_back({1'b1, eg_w, 64'h0});
        else exp_q.push_back({1'b0, eg_w, ~cur_opx, cur_opx ^ CMASK});
        wait_q.push_back(unit_mode == 2 ? TO : (unit_mode == 1 ? MW + 1 : lat + 1));
      end else check("rdy_idle", req_ready, 0);

      if (unit_start) begin
        n_starts++; wait_cycles = 0;
        check("start_opx", unit_opx, cur_opx);
      end else if (busy && !rsp_valid) begin
        wait_cycles++;
        check("wait_opx", unit_opx, cur_opx);
      end

      if (rsp_valid) begin
        if (!prev_rv) begin
          if (wait_q.size() == 0) check("wait_q_empty", 0, 1);
          else check("wait_len", wait_cycles, wait_q.pop_front());
          check("start_pulses", n_starts, 1);
        end
        if (stall_prev) check("rsp_stable", got_rsp, held_rsp);
        if (rsp_ready) begin
          if (exp_q.size() == 0) check("rsp_unexpected", 0, 1);
          else check("rsp_data", got_rsp, exp_q.pop_front());
          n_rsp++;
        end
        stall_prev = !rsp_ready; held_rsp = got_rsp;
      end else stall_prev = 1'b0;
      prev_rv = rsp_valid;
    end
  end

  // ---------------- driver tasks (called at posedge + #1)
  task automatic wait_grants(input int t, input string tag);
    int k = 0;
    while (n_grants < t && k < 200) begin @(posedge clk); #1; k++; end
    if (n_grants < t) check(tag, 0, 1);
  endtask

  task automatic wait_rsp(input int t, input string tag, input int budget);
    int k = 0;
    while (n_rsp < t && k < budget) begin @(posedge clk); #1; k++; end
    if (n_rsp < t) check(tag, 0, 1);
  endtask

  task automatic issue_one(input int id, input logic [31:0] opx);
    int g0, r0;
    g0 = n_grants; r0 = n_rsp;
    req_opx[32*id +: 32] = opx;
    req_valid[id] = 1'b1;
    wait_grants(g0 + 1, "grant_wait");
    req_valid[id] = 1'b0;
    wait_rsp(r0 + 1, "rsp_wait", 300);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_unit_start"}, unit_start, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_unit_opx"}, unit_opx, 0);
    check({tag, "_rsp"}, got_rsp, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  // ---------------- stimulus
  initial begin
    int exp_order[5];
    int r0, g0, k;
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = '0; req_opx = '0; rsp_ready = 1'b1; n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // round-robin with everyone requesting
    for (int i = 0; i < NR; i++) req_opx[32*i +: 32] = 32'h40000000 + i;
    r0 = n_rsp;
    req_valid = '1;
    wait_grants(5, "rr_grants");
    req_valid = '0;
    wait_rsp(r0 + 5, "rr_rsp", 300);
    for (int i = 0; i < 5; i++)
      if (grant_log.size() > i) check("rr_order", grant_log[i], exp_order[i]);
      else check("rr_order_missing", 0, 1);

    // single request with latency 2
    unit_mode = 0; lat = 2;
    issue_one(0, 32'h3FC90FDB);

    // done held high: captured at WAIT index MIN_WAIT
    unit_mode = 1;
    issue_one(1, 32'h40490FDB);
    unit_mode = 0;

    // timeout, then a normal operation
    unit_mode = 2;
    issue_one(2, 32'h3F800000);
    unit_mode = 0;
    issue_one(2, 32'h3F000000);

    // backpressure with a competing request pending
    lat = 3; rsp_ready = 1'b0;
    g0 = n_grants; r0 = n_rsp;
    req_opx[32*3 +: 32] = 32'h12345678; req_valid[3] = 1'b1;
    wait_grants(g0 + 1, "bp_grant");
    req_valid[3] = 1'b0;
    k = 0;
    while (!rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
    if (!rsp_valid) check("bp_rsp_wait", 0, 1);
    req_opx[32*1 +: 32] = 32'h0BADF00D; req_valid[1] = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("bp_no_grant", n_grants, g0 + 1);
    rsp_ready = 1'b1;
    wait_grants(g0 + 2, "bp_grant2");
    req_valid[1] = 1'b0;
    wait_rsp(r0 + 2, "bp_rsp", 300);

    // random masks, operands and latencies
    for (int n = 0; n < 8; n++) begin
      lat = $urandom_range(1, 6);
      for (int i = 0; i < NR; i++) req_opx[32*i +: 32] = $urandom;
      g0 = n_grants; r0 = n_rsp;
      req_valid = NR'($urandom_range(1, 15));
      wait_grants(g0 + 1, "rand_grant");
      req_valid = '0;
      wait_rsp(r0 + 1, "rand_rsp", 300);
    end

    // reset at WAIT index 0
    lat = 3;
    g0 = n_grants; r0 = n_rsp;
    req_opx[32*2 +: 32] = 32'hCAFEF00D; req_valid[2] = 1'b1;
    wait_grants(g0 + 1, "rst_grant");
    req_valid[2] = 1'b0;
    k = 0;
    while (!(busy && !unit_start && !rsp_valid) && k < 20) begin @(posedge clk); #1; k++; end
    n_rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete(); wait_q.delete(); tb_rr = 0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check("midrst_no_rsp", n_rsp, r0);
    g0 = n_grants;
    req_valid = '1;
    wait_grants(g0 + 1, "post_rst_grant");
    req_valid = '0;
    check("post_rst_first", last_g, 0);
    wait_rsp(r0 + 1, "post_rst_rsp", 300);

    check("q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
